// File: rtl/ram_pkg.sv
// Shared constants and helpers for the byte-enable dual-port RAM and its init controller.
package ram_pkg;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   localparam logic ST_INIT  = 1'b0;
   localparam logic ST_READY = 1'b1;

   function automatic int num_bytes(input int word_length, input int byte_width);
      return word_length / byte_width;
   endfunction

endpackage

// File: rtl/ram_init_ctrl.sv
// Post-reset zero-clear sequencer: walks every address once, then declares the array ready.
module ram_init_ctrl
   import ram_pkg::*;
#(
   parameter int ADDR_BITS  = 8,
   parameter int INIT_CLEAR = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   output logic                 o_clr_we,
   output logic [ADDR_BITS-1:0] o_clr_addr,
   output logic                 o_ready,
   output logic                 o_state
);

   logic                 state;
   logic [ADDR_BITS-1:0] clr_addr;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state    <= (INIT_CLEAR != 0) ? ST_INIT : ST_READY;
         clr_addr <= '0;
      end else if (state == ST_INIT) begin
         clr_addr <= clr_addr + 1'b1;
         // The last address is cleared on this edge, so ready rises together with it.
         if (clr_addr == '1) begin
            state <= ST_READY;
         end
      end
   end

   assign o_clr_we   = (state == ST_INIT);
   assign o_clr_addr = clr_addr;
   assign o_ready    = (state == ST_READY);
   assign o_state    = state;

endmodule

// File: rtl/ram_dualport_be.sv
// Single-clock simple dual-port RAM with byte-lane writes, selectable read-during-write
// behaviour and a 1- or 2-stage registered read path.
module ram_dualport_be
   import ram_pkg::*;
#(
   parameter int  ADDR_BITS    = 8,
   parameter int  WORD_LENGTH  = 32,
   parameter int  BYTE_WIDTH   = 8,
   parameter int  READ_LATENCY = 1,
   parameter int  RDW_MODE     = 0,
   parameter int  INIT_CLEAR   = 1,
   localparam int NUM_BYTES    = num_bytes(WORD_LENGTH, BYTE_WIDTH)
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   output logic                   o_ready,
   output logic                   o_state,
   input  logic                   i_we,
   input  logic [NUM_BYTES-1:0]   i_be,
   input  logic [ADDR_BITS-1:0]   i_waddr,
   input  logic [WORD_LENGTH-1:0] i_wdata,
   input  logic                   i_re,
   input  logic [ADDR_BITS-1:0]   i_raddr,
   output logic                   o_rvalid,
   output logic [WORD_LENGTH-1:0] o_rdata
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   if ((WORD_LENGTH % BYTE_WIDTH) != 0) begin : g_bad_byte_width
      $fatal(1, "ram_dualport_be: WORD_LENGTH must be a multiple of BYTE_WIDTH");
   end
   if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
      $fatal(1, "ram_dualport_be: READ_LATENCY must be 1 or 2");
   end

   logic                   clr_we;
   logic [ADDR_BITS-1:0]   clr_addr;
   logic                   ready;
   logic                   rd_acc;
   logic [WORD_LENGTH-1:0] rd_word;
   logic                   v1;
   logic [WORD_LENGTH-1:0] d1;
   logic [WORD_LENGTH-1:0] mem [DEPTH];

   ram_init_ctrl #(
      .ADDR_BITS  (ADDR_BITS),
      .INIT_CLEAR (INIT_CLEAR)
   ) u_init_ctrl (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .o_clr_we   (clr_we),
      .o_clr_addr (clr_addr),
      .o_ready    (ready),
      .o_state    (o_state)
   );

   assign o_ready = ready;
   assign rd_acc  = ready && i_re;

   // Clear sweep owns the write port while it runs; user writes only land once ready.
   always_ff @(posedge i_clk) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else if (ready && i_we) begin
         for (int k = 0; k < NUM_BYTES; k++) begin
            if (i_be[k]) begin
               mem[i_waddr][k*BYTE_WIDTH +: BYTE_WIDTH] <= i_wdata[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   // In new-data mode a colliding read sees the enabled lanes of the incoming write.
   always_comb begin
      rd_word = mem[i_raddr];
      if ((RDW_MODE == RDW_NEW) && i_we && (i_waddr == i_raddr)) begin
         for (int k = 0; k < NUM_BYTES; k++) begin
            if (i_be[k]) begin
               rd_word[k*BYTE_WIDTH +: BYTE_WIDTH] = i_wdata[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         v1 <= 1'b0;
         d1 <= '0;
      end else begin
         v1 <= rd_acc;
         if (rd_acc) begin
            d1 <= rd_word;
         end
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic                   v2;
      logic [WORD_LENGTH-1:0] d2;

      always_ff @(posedge i_clk) begin
         if (!i_rst_n) begin
            v2 <= 1'b0;
            d2 <= '0;
         end else begin
            v2 <= v1;
            if (v1) begin
               d2 <= d1;
            end
         end
      end

      assign o_rvalid = v2;
      assign o_rdata  = d2;
   end else begin : g_lat1
      assign o_rvalid = v1;
      assign o_rdata  = d1;
   end

endmodule

// File: tb/tb_ram_dualport_be.sv
// Directed bench for ram_dualport_be: two instances share stimulus, one with old-data
// collisions and 1-cycle reads, the other with new-data collisions and 2-cycle reads.
module tb_ram_dualport_be;

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [3:0]  waddr;
      logic [31:0] wdata;
      logic        re;
      logic [3:0]  raddr;
      logic [31:0] exp_data;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we;
   logic [3:0]  be;
   logic [3:0]  waddr;
   logic [31:0] wdata;
   logic        re;
   logic [3:0]  raddr;

   logic        a_ready, a_state, a_rvalid;
   logic [31:0] a_rdata;
   logic        b_ready, b_state, b_rvalid;
   logic [31:0] b_rdata;

   int checks   = 0;
   int failures = 0;

   vec_t vecs [11];

   always #5 clk = ~clk;

   ram_dualport_be #(
      .ADDR_BITS(4), .WORD_LENGTH(32), .BYTE_WIDTH(8),
      .READ_LATENCY(1), .RDW_MODE(0), .INIT_CLEAR(1)
   ) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .o_ready(a_ready), .o_state(a_state),
      .i_we(we), .i_be(be), .i_waddr(waddr), .i_wdata(wdata),
      .i_re(re), .i_raddr(raddr), .o_rvalid(a_rvalid), .o_rdata(a_rdata)
   );

   ram_dualport_be #(
      .ADDR_BITS(4), .WORD_LENGTH(32), .BYTE_WIDTH(8),
      .READ_LATENCY(2), .RDW_MODE(1), .INIT_CLEAR(1)
   ) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .o_ready(b_ready), .o_state(b_state),
      .i_we(we), .i_be(be), .i_waddr(waddr), .i_wdata(wdata),
      .i_re(re), .i_raddr(raddr), .o_rvalid(b_rvalid), .o_rdata(b_rdata)
   );

   // Advance past the next rising edge; outputs are sampled and inputs driven 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      we    = 1'b0;
      be    = 4'h0;
      waddr = 4'd0;
      wdata = 32'h0;
      re    = 1'b0;
      raddr = 4'd0;
   endtask

   task automatic write_word(input logic [3:0] a, input logic [31:0] d, input logic [3:0] lanes);
      we = 1'b1; be = lanes; waddr = a; wdata = d;
      tick();
      idle_inputs();
   endtask

   task automatic wait_ready_16(input string tag);
      for (int i = 1; i <= 16; i++) begin
         tick();
         check({tag, "_ready_a"}, {31'd0, a_ready}, {31'd0, i == 16});
         check({tag, "_ready_b"}, {31'd0, b_ready}, {31'd0, i == 16});
         check({tag, "_rvalid_init"}, {30'd0, a_rvalid, b_rvalid}, 32'd0);
      end
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;

      vecs[0]  = '{1'b1, 4'hF, 4'd3,  32'hAABBCCDD, 1'b0, 4'd0,  32'h0};
      vecs[1]  = '{1'b1, 4'h5, 4'd3,  32'h11223344, 1'b0, 4'd0,  32'h0};
      vecs[2]  = '{1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 4'd3,  32'hAA22CC44};
      vecs[3]  = '{1'b1, 4'h2, 4'd7,  32'hFFFF5AFF, 1'b0, 4'd0,  32'h0};
      vecs[4]  = '{1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 4'd7,  32'h00005A00};
      vecs[5]  = '{1'b1, 4'hF, 4'd5,  32'h01020304, 1'b0, 4'd0,  32'h0};
      vecs[6]  = '{1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 4'd5,  32'h01020304};
      vecs[7]  = '{1'b1, 4'h0, 4'd5,  32'hFFFFFFFF, 1'b0, 4'd0,  32'h0};
      vecs[8]  = '{1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 4'd5,  32'h01020304};
      vecs[9]  = '{1'b1, 4'h8, 4'd15, 32'h12345678, 1'b0, 4'd0,  32'h0};
      vecs[10] = '{1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 4'd15, 32'h12000000};

      // Reset state and clear sweep timing.
      tick();
      tick();
      check("rst_ready_a", {31'd0, a_ready}, 32'd0);
      check("rst_state_a", {31'd0, a_state}, 32'd0);
      check("rst_rvalid_a", {31'd0, a_rvalid}, 32'd0);
      check("rst_rdata_a", a_rdata, 32'h0);
      check("rst_rdata_b", b_rdata, 32'h0);
      rst_n = 1'b1;
      wait_ready_16("init");
      check("ready_state_a", {31'd0, a_state}, 32'd1);

      // Back-to-back reads of every cleared address.
      for (int i = 0; i < 16; i++) begin
         re = 1'b1;
         raddr = 4'(i);
         tick();
         check("clr_read_valid", {31'd0, a_rvalid}, 32'd1);
         check("clr_read_data", a_rdata, 32'h0);
      end
      idle_inputs();
      tick();
      tick();

      // Table-driven writes and isolated reads.
      foreach (vecs[n]) begin
         we = vecs[n].we; be = vecs[n].be; waddr = vecs[n].waddr;
         wdata = vecs[n].wdata; re = vecs[n].re; raddr = vecs[n].raddr;
         tick();
         idle_inputs();
         check("vec_valid_a", {31'd0, a_rvalid}, {31'd0, vecs[n].re});
         if (vecs[n].re) check("vec_data_a", a_rdata, vecs[n].exp_data);
         tick();
         check("vec_valid_b", {31'd0, b_rvalid}, {31'd0, vecs[n].re});
         if (vecs[n].re) check("vec_data_b", b_rdata, vecs[n].exp_data);
      end

      // Full-word collision on addr 5, then a follow-up read the next cycle.
      we = 1'b1; be = 4'hF; waddr = 4'd5; wdata = 32'hDEADBEEF; re = 1'b1; raddr = 4'd5;
      tick();
      we = 1'b0; be = 4'h0;
      check("rdw_old_a", a_rdata, 32'h01020304);
      check("rdw_old_valid_a", {31'd0, a_rvalid}, 32'd1);
      tick();
      re = 1'b0;
      check("rdw_next_a", a_rdata, 32'hDEADBEEF);
      check("rdw_new_b", b_rdata, 32'hDEADBEEF);
      tick();
      check("rdw_next_b", b_rdata, 32'hDEADBEEF);
      tick();

      // Partial-lane collision on addr 3 (holds 0xAA22CC44).
      we = 1'b1; be = 4'h3; waddr = 4'd3; wdata = 32'h99887766; re = 1'b1; raddr = 4'd3;
      tick();
      idle_inputs();
      check("rdw_part_old_a", a_rdata, 32'hAA22CC44);
      tick();
      check("rdw_part_new_b", b_rdata, 32'hAA227766);
      tick();

      // Latency-2 streaming reads on addrs 0..2.
      write_word(4'd0, 32'hA0A0A0A0, 4'hF);
      write_word(4'd1, 32'hA1A1A1A1, 4'hF);
      write_word(4'd2, 32'hA2A2A2A2, 4'hF);
      re = 1'b1; raddr = 4'd0;
      tick();
      check("lat2_first_b", {31'd0, b_rvalid}, 32'd0);
      raddr = 4'd1;
      tick();
      check("lat2_v0_b", {31'd0, b_rvalid}, 32'd1);
      check("lat2_d0_b", b_rdata, 32'hA0A0A0A0);
      raddr = 4'd2;
      tick();
      re = 1'b0;
      check("lat2_v1_b", {31'd0, b_rvalid}, 32'd1);
      check("lat2_d1_b", b_rdata, 32'hA1A1A1A1);
      tick();
      check("lat2_v2_b", {31'd0, b_rvalid}, 32'd1);
      check("lat2_d2_b", b_rdata, 32'hA2A2A2A2);
      tick();
      check("lat2_end_b", {31'd0, b_rvalid}, 32'd0);
      check("lat2_hold_b", b_rdata, 32'hA2A2A2A2);

      // Reset mid-clear at step 7 with user traffic held active throughout INIT.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      we = 1'b1; be = 4'hF; waddr = 4'd2; wdata = 32'hFFFFFFFF; re = 1'b1; raddr = 4'd2;
      for (int i = 0; i < 7; i++) tick();
      check("midclr_ready_a", {31'd0, a_ready}, 32'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      wait_ready_16("restart");
      idle_inputs();
      re = 1'b1; raddr = 4'd2;
      tick();
      idle_inputs();
      check("init_wr_ignored_a", a_rdata, 32'h0);
      tick();
      check("init_wr_ignored_b", b_rdata, 32'h0);

      // Read in flight on the 2-stage instance when reset hits.
      write_word(4'd9, 32'h5555AAAA, 4'hF);
      re = 1'b1; raddr = 4'd9;
      tick();
      re = 1'b0;
      rst_n = 1'b0;
      tick();
      check("flush_valid_b", {31'd0, b_rvalid}, 32'd0);
      check("flush_rdata_b", b_rdata, 32'h0);
      check("flush_rdata_a", a_rdata, 32'h0);
      tick();
      check("flush_valid_b2", {31'd0, b_rvalid}, 32'd0);
      rst_n = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
